control_sequencer: RTL and testbench
====================================

Name: control_sequencer

Overview:
- Multi-cycle fetch/decode/execute sequencer for the 8-bit CPU.
- Drives the instruction register's load strobe and consumes the register's held instruction.
- Generates every per-cycle control strobe for the PC, MAR, memory, A/B registers, ALU, flags and output register.
- Stalls on a memory-ready handshake.
- Instruction format: opcode = instruction[7:4], operand = instruction[3:0].

Parameters:
- none (opcode map and state encodings come from defines.vh)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous active-low reset
- instruction  in  8  current contents of the instruction register
- flag_c  in  1  registered ALU carry flag
- flag_z  in  1  registered ALU zero flag
- mem_ready  in  1  memory has completed the current read/write this cycle
- load_ir  out  1  instruction register load enable
- mar_load_pc  out  1  MAR <= PC
- mar_load_ir  out  1  MAR <= instruction[3:0]
- pc_inc  out  1  PC <= PC+1
- pc_load  out  1  PC <= instruction[3:0]
- mem_rd  out  1  memory read request
- mem_wr  out  1  memory write request, data = A
- a_load_mem  out  1  A <= memory data
- a_load_imm  out  1  A <= {4'b0, instruction[3:0]}
- a_load_alu  out  1  A <= ALU result
- b_load  out  1  B <= memory data
- alu_sub  out  1  ALU performs A-B (else A+B)
- flags_load  out  1  capture carry/zero from ALU
- out_load  out  1  output register <= A
- illegal_op  out  1  one-cycle pulse on undefined opcode
- halted  out  1  high while in HALT
- t_state  out  3  current state encoding (debug)

Behaviour:
- States: FETCH_ADDR=0, FETCH_MEM=1, DECODE=2, EXEC_MEM=3, EXEC_ALU=4, EXEC_WR=5, HALT=7. State register is the only storage; all strobes are combinational from state, instruction, flags and mem_ready.
- reset_n low: state -> FETCH_ADDR asynchronously; every output forced 0 (t_state=0) while reset_n is low, including mid-instruction. First cycle after release is FETCH_ADDR.
- FETCH_ADDR: mar_load_pc=1 -> FETCH_MEM.
- FETCH_MEM: mem_rd=1. While mem_ready=0, hold state with no other strobes. When mem_ready=1: load_ir=1, pc_inc=1 -> DECODE.
- DECODE: instruction is valid this cycle. Actions by opcode:
  - NOP 0x0 -> FETCH_ADDR.
  - LDA 0x1, ADD 0x2, SUB 0x3: mar_load_ir=1 -> EXEC_MEM.
  - STA 0x4: mar_load_ir=1 -> EXEC_WR.
  - LDI 0x5: a_load_imm=1 -> FETCH_ADDR.
  - JMP 0x6: pc_load=1 -> FETCH_ADDR.
  - JC 0x7: pc_load=flag_c -> FETCH_ADDR.
  - JZ 0x8: pc_load=flag_z -> FETCH_ADDR.
  - OUT 0xE: out_load=1 -> FETCH_ADDR.
  - HLT 0xF -> HALT.
  - 0x9..0xD: illegal_op=1 for this cycle only, otherwise behaves as NOP.
- EXEC_MEM: mem_rd=1; hold until mem_ready=1. When ready: LDA asserts a_load_mem -> FETCH_ADDR; ADD/SUB assert b_load -> EXEC_ALU.
- EXEC_ALU: a_load_alu=1, flags_load=1, alu_sub=(opcode==SUB) -> FETCH_ADDR.
- EXEC_WR: mem_wr=1; hold until mem_ready=1 -> FETCH_ADDR.
- HALT: halted=1, all other strobes 0. Exit only via reset_n.
- Zero-wait latencies (cycles from FETCH_ADDR to the next FETCH_ADDR):
  - NOP/LDI/JMP/JC/JZ/OUT: 3
  - LDA/STA: 4
  - ADD/SUB: 5
  - Each cycle of mem_ready=0 in a memory state adds 1.
- Mutual exclusion: at most one of mar_load_pc/mar_load_ir is high; at most one of the a_load_* strobes is high; pc_inc and pc_load are never high together; mem_rd and mem_wr are never high together.
- Flags are sampled only in DECODE; a flag change in any other cycle has no effect.
- mem_ready is ignored outside FETCH_MEM, EXEC_MEM and EXEC_WR.

Decomposition:
- defines.vh gets:
  - opcode constants OP_NOP..OP_HLT
  - state encodings ST_FETCH_ADDR..ST_HALT
  - field-slice macros for opcode and operand
- One natural sub-module: sequencer_decode (combinational opcode -> class bits: is_mem_read, is_alu, is_store, is_jump, is_illegal), instantiated once in DECODE/EXEC logic.

Test Plan:
- Reset mid-instruction: assert reset_n=0 during EXEC_MEM of LDA -> all outputs 0 immediately; after release, t_state=0 and mar_load_pc=1 on the first cycle.
- mem_ready tied 1; instruction sequence 0x53 (LDI 3), 0x2A (ADD 10), 0xE0 (OUT):
  - LDI: a_load_imm in cycle 3.
  - ADD: b_load in cycle 4, a_load_alu+flags_load with alu_sub=0 in cycle 5.
  - OUT: out_load in cycle 3.
  - Total 11 cycles.
- mem_ready held 0 for 4 cycles in FETCH_MEM, then 1 -> state stays 1 with only mem_rd high; load_ir+pc_inc pulse exactly once; 7 cycles total for NOP.
- JC 0x75 with flag_c=0 then flag_c=1 -> pc_load low then high in DECODE; both take 3 cycles; JZ 0x85 checked the same way with flag_z.
- STA 0x4F with mem_ready delayed 2 cycles in EXEC_WR -> mar_load_ir in DECODE, mem_wr high 3 cycles, then FETCH_ADDR.
- Opcode 0xB0 -> illegal_op high for 1 cycle, returns to FETCH_ADDR. Opcode 0xF0 -> halted=1, t_state=7 held for 20+ cycles regardless of mem_ready/flags; reset_n pulse recovers.

Source files
------------

// File: rtl/control_sequencer_pkg.sv
// Shared types for the 8-bit CPU control sequencer: state encoding, opcode map,
// decoded opcode class bits and the bundled per-cycle control strobes.
package control_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_FETCH_ADDR = 3'd0,
        ST_FETCH_MEM  = 3'd1,
        ST_DECODE     = 3'd2,
        ST_EXEC_MEM   = 3'd3,
        ST_EXEC_ALU   = 3'd4,
        ST_EXEC_WR    = 3'd5,
        ST_HALT       = 3'd7
    } state_t;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef struct packed {
        logic is_mem_read;
        logic is_alu;
        logic is_store;
        logic is_jump;
        logic is_illegal;
    } op_class_t;

    typedef struct packed {
        logic load_ir;
        logic mar_load_pc;
        logic mar_load_ir;
        logic pc_inc;
        logic pc_load;
        logic mem_rd;
        logic mem_wr;
        logic a_load_mem;
        logic a_load_imm;
        logic a_load_alu;
        logic b_load;
        logic alu_sub;
        logic flags_load;
        logic out_load;
        logic illegal_op;
        logic halted;
    } strobes_t;

    function automatic logic [3:0] opcode_of(input logic [7:0] instr);
        return instr[7:4];
    endfunction

endpackage

// File: rtl/control_sequencer_decode.sv
// Combinational opcode classifier: groups opcodes by the execute path they take.
module sequencer_decode
    import control_sequencer_pkg::*;
(
    input  logic [3:0] i_opcode,
    output op_class_t  o_class
);

    always_comb begin
        o_class = '0;
        case (i_opcode)
            OP_LDA: o_class.is_mem_read = 1'b1;
            OP_ADD,
            OP_SUB: begin
                o_class.is_mem_read = 1'b1;
                o_class.is_alu      = 1'b1;
            end
            OP_STA: o_class.is_store = 1'b1;
            OP_JMP,
            OP_JC,
            OP_JZ:  o_class.is_jump = 1'b1;
            4'h9, 4'hA, 4'hB, 4'hC, 4'hD:
                    o_class.is_illegal = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer: one state register, all control
// strobes decoded combinationally from state, instruction, flags and mem_ready.
module control_sequencer
    import control_sequencer_pkg::*;
(
    input  logic       clk,
    input  logic       reset_n,
    input  logic [7:0] instruction,
    input  logic       flag_c,
    input  logic       flag_z,
    input  logic       mem_ready,
    output logic       load_ir,
    output logic       mar_load_pc,
    output logic       mar_load_ir,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mem_rd,
    output logic       mem_wr,
    output logic       a_load_mem,
    output logic       a_load_imm,
    output logic       a_load_alu,
    output logic       b_load,
    output logic       alu_sub,
    output logic       flags_load,
    output logic       out_load,
    output logic       illegal_op,
    output logic       halted,
    output logic [2:0] t_state
);

    state_t    r_state;
    state_t    w_next;
    strobes_t  w_strb;
    op_class_t w_class;
    logic [3:0] w_opcode;
    logic       w_unused_operand;

    assign w_opcode         = opcode_of(instruction);
    assign w_unused_operand = ^instruction[3:0];

    sequencer_decode u_decode (
        .i_opcode (w_opcode),
        .o_class  (w_class)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_FETCH_ADDR;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        w_strb = '0;
        case (r_state)
            ST_FETCH_ADDR: begin
                w_strb.mar_load_pc = 1'b1;
                w_next             = ST_FETCH_MEM;
            end
            ST_FETCH_MEM: begin
                w_strb.mem_rd = 1'b1;
                if (mem_ready) begin
                    w_strb.load_ir = 1'b1;
                    w_strb.pc_inc  = 1'b1;
                    w_next         = ST_DECODE;
                end
            end
            ST_DECODE: begin
                w_next = ST_FETCH_ADDR;
                if (w_class.is_illegal) begin
                    w_strb.illegal_op = 1'b1;
                end else if (w_class.is_mem_read || w_class.is_store) begin
                    w_strb.mar_load_ir = 1'b1;
                    w_next = w_class.is_store ? ST_EXEC_WR : ST_EXEC_MEM;
                end else if (w_class.is_jump) begin
                    // Flags only matter here; conditional jumps sample them in DECODE.
                    w_strb.pc_load = (w_opcode == OP_JMP)
                                   | ((w_opcode == OP_JC) & flag_c)
                                   | ((w_opcode == OP_JZ) & flag_z);
                end else begin
                    case (w_opcode)
                        OP_LDI:  w_strb.a_load_imm = 1'b1;
                        OP_OUT:  w_strb.out_load   = 1'b1;
                        OP_HLT:  w_next            = ST_HALT;
                        default: ;
                    endcase
                end
            end
            ST_EXEC_MEM: begin
                w_strb.mem_rd = 1'b1;
                if (mem_ready) begin
                    if (w_class.is_alu) begin
                        w_strb.b_load = 1'b1;
                        w_next        = ST_EXEC_ALU;
                    end else begin
                        w_strb.a_load_mem = 1'b1;
                        w_next            = ST_FETCH_ADDR;
                    end
                end
            end
            ST_EXEC_ALU: begin
                w_strb.a_load_alu = 1'b1;
                w_strb.flags_load = 1'b1;
                w_strb.alu_sub    = (w_opcode == OP_SUB);
                w_next            = ST_FETCH_ADDR;
            end
            ST_EXEC_WR: begin
                w_strb.mem_wr = 1'b1;
                if (mem_ready) begin
                    w_next = ST_FETCH_ADDR;
                end
            end
            ST_HALT: begin
                w_strb.halted = 1'b1;
            end
            default: begin
                w_next = ST_FETCH_ADDR;
            end
        endcase
        // The state register already sits in FETCH_ADDR during reset; this also
        // silences its mar_load_pc so every strobe reads 0 while reset_n is low.
        if (!reset_n) begin
            w_strb = '0;
        end
    end

    assign load_ir     = w_strb.load_ir;
    assign mar_load_pc = w_strb.mar_load_pc;
    assign mar_load_ir = w_strb.mar_load_ir;
    assign pc_inc      = w_strb.pc_inc;
    assign pc_load     = w_strb.pc_load;
    assign mem_rd      = w_strb.mem_rd;
    assign mem_wr      = w_strb.mem_wr;
    assign a_load_mem  = w_strb.a_load_mem;
    assign a_load_imm  = w_strb.a_load_imm;
    assign a_load_alu  = w_strb.a_load_alu;
    assign b_load      = w_strb.b_load;
    assign alu_sub     = w_strb.alu_sub;
    assign flags_load  = w_strb.flags_load;
    assign out_load    = w_strb.out_load;
    assign illegal_op  = w_strb.illegal_op;
    assign halted      = w_strb.halted;
    assign t_state     = r_state;

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer: per-instruction expected traces built
// from the instruction semantics, directed table, random program, hand corner cases.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] instruction;
    logic       flag_c, flag_z, mem_ready;
    logic       load_ir, mar_load_pc, mar_load_ir, pc_inc, pc_load, mem_rd, mem_wr;
    logic       a_load_mem, a_load_imm, a_load_alu, b_load, alu_sub, flags_load;
    logic       out_load, illegal_op, halted;
    logic [2:0] t_state;

    always #5 clk = ~clk;

    control_sequencer dut (
        .clk(clk), .reset_n(reset_n), .instruction(instruction),
        .flag_c(flag_c), .flag_z(flag_z), .mem_ready(mem_ready),
        .load_ir(load_ir), .mar_load_pc(mar_load_pc), .mar_load_ir(mar_load_ir),
        .pc_inc(pc_inc), .pc_load(pc_load), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .a_load_mem(a_load_mem), .a_load_imm(a_load_imm), .a_load_alu(a_load_alu),
        .b_load(b_load), .alu_sub(alu_sub), .flags_load(flags_load),
        .out_load(out_load), .illegal_op(illegal_op), .halted(halted),
        .t_state(t_state)
    );

    localparam logic [15:0] S_LOAD_IR = 16'h8000, S_MAR_PC = 16'h4000, S_MAR_IR = 16'h2000;
    localparam logic [15:0] S_PC_INC  = 16'h1000, S_PC_LD  = 16'h0800, S_MEM_RD = 16'h0400;
    localparam logic [15:0] S_MEM_WR  = 16'h0200, S_A_MEM  = 16'h0100, S_A_IMM  = 16'h0080;
    localparam logic [15:0] S_A_ALU   = 16'h0040, S_B_LD   = 16'h0020, S_SUB    = 16'h0010;
    localparam logic [15:0] S_FLAGS   = 16'h0008, S_OUT    = 16'h0004, S_ILL    = 16'h0002;
    localparam logic [15:0] S_HALT    = 16'h0001;

    wire [15:0] obs = {load_ir, mar_load_pc, mar_load_ir, pc_inc, pc_load, mem_rd, mem_wr,
                       a_load_mem, a_load_imm, a_load_alu, b_load, alu_sub, flags_load,
                       out_load, illegal_op, halted};

    typedef struct packed {
        logic        rdy, fc, fz;
        logic [2:0]  st;
        logic [15:0] strb;
    } tr_t;

    typedef struct {
        logic [7:0]  ins;
        logic        fc, fz;
        int unsigned fw, ew, lat;
    } vec_t;

    tr_t  trace_q[$];
    vec_t tbl[13];
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [2:0] last_st;

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    task automatic chk(input string name, input logic [18:0] act, input logic [18:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Called at posedge+1; drives inputs, samples at negedge, advances one cycle.
    task automatic step(input logic rdy, input logic fc, input logic fz,
                        input logic [2:0] est, input logic [15:0] estb, input string name);
        logic bad;
        mem_ready = rdy; flag_c = fc; flag_z = fz;
        @(negedge clk);
        chk(name, {t_state, obs}, {est, estb});
        bad = (mar_load_pc & mar_load_ir) | (pc_inc & pc_load) | (mem_rd & mem_wr)
            | (32'(a_load_mem) + 32'(a_load_imm) + 32'(a_load_alu) > 1);
        chk({name, "_mutex"}, 19'(bad), 19'd0);
        last_st = t_state;
        @(posedge clk); #1;
    endtask

    task automatic push(input logic rdy, input logic fc, input logic fz,
                        input logic [2:0] st, input logic [15:0] strb);
        trace_q.push_back('{rdy: rdy, fc: fc, fz: fz, st: st, strb: strb});
    endtask

    // Expected cycle-by-cycle behaviour of one instruction, from its semantics.
    task automatic gen(input logic [7:0] ins, input int unsigned fw, input int unsigned ew,
                       input logic fc, input logic fz);
        logic [3:0]  op;
        logic [15:0] d;
        op = ins[7:4];
        trace_q.delete();
        push(rb(), rb(), rb(), 3'd0, S_MAR_PC);
        repeat (fw) push(1'b0, rb(), rb(), 3'd1, S_MEM_RD);
        push(1'b1, rb(), rb(), 3'd1, S_MEM_RD | S_LOAD_IR | S_PC_INC);
        case (op)
            4'h0, 4'hF:             d = '0;
            4'h1, 4'h2, 4'h3, 4'h4: d = S_MAR_IR;
            4'h5:                   d = S_A_IMM;
            4'h6:                   d = S_PC_LD;
            4'h7:                   d = fc ? S_PC_LD : 16'h0;
            4'h8:                   d = fz ? S_PC_LD : 16'h0;
            4'hE:                   d = S_OUT;
            default:                d = S_ILL;
        endcase
        push(rb(), fc, fz, 3'd2, d);
        if (op >= 4'h1 && op <= 4'h3) begin
            repeat (ew) push(1'b0, rb(), rb(), 3'd3, S_MEM_RD);
            push(1'b1, rb(), rb(), 3'd3, S_MEM_RD | ((op == 4'h1) ? S_A_MEM : S_B_LD));
            if (op != 4'h1)
                push(rb(), rb(), rb(), 3'd4, S_A_ALU | S_FLAGS | ((op == 4'h3) ? S_SUB : 16'h0));
        end else if (op == 4'h4) begin
            repeat (ew) push(1'b0, rb(), rb(), 3'd5, S_MEM_WR);
            push(1'b1, rb(), rb(), 3'd5, S_MEM_WR);
        end
    endtask

    task automatic run_trace(input string name, input int unsigned exp_lat);
        int unsigned lat = 0;
        int unsigned len = trace_q.size();
        for (int unsigned i = 0; i < len; i++) begin
            step(trace_q[i].rdy, trace_q[i].fc, trace_q[i].fz,
                 trace_q[i].st, trace_q[i].strb, name);
            if (i > 0 && last_st == 3'd0 && lat == 0) lat = i;
        end
        if (lat == 0 && t_state == 3'd0) lat = len;
        chk({name, "_latency"}, 19'(lat), 19'(exp_lat));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        tbl[0]  = '{8'h53, 0, 0, 0, 0, 3};
        tbl[1]  = '{8'h2A, 0, 0, 0, 0, 5};
        tbl[2]  = '{8'hE0, 0, 0, 0, 0, 3};
        tbl[3]  = '{8'h00, 0, 0, 4, 0, 7};
        tbl[4]  = '{8'h75, 0, 0, 0, 0, 3};
        tbl[5]  = '{8'h75, 1, 0, 0, 0, 3};
        tbl[6]  = '{8'h85, 1, 0, 0, 0, 3};
        tbl[7]  = '{8'h85, 0, 1, 0, 0, 3};
        tbl[8]  = '{8'h4F, 0, 0, 0, 2, 6};
        tbl[9]  = '{8'hB0, 1, 1, 0, 0, 3};
        tbl[10] = '{8'h1C, 0, 0, 0, 1, 5};
        tbl[11] = '{8'h37, 1, 0, 1, 1, 7};
        tbl[12] = '{8'h60, 0, 0, 0, 0, 3};

        reset_n = 1'b0; instruction = '0; flag_c = 0; flag_z = 0; mem_ready = 0;
        #12;
        chk("reset_outputs", {t_state, obs}, 19'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;

        foreach (tbl[k]) begin
            instruction = tbl[k].ins;
            gen(tbl[k].ins, tbl[k].fw, tbl[k].ew, tbl[k].fc, tbl[k].fz);
            run_trace($sformatf("vec%0d_%h", k, tbl[k].ins), tbl[k].lat);
        end

        for (int n = 0; n < 80; n++) begin
            logic [3:0]  op;
            int unsigned fw, ew, lat;
            op = 4'($urandom_range(0, 14));
            fw = $urandom_range(0, 3);
            ew = $urandom_range(0, 3);
            instruction = {op, 4'($urandom_range(0, 15))};
            lat = 3 + fw;
            if (op >= 4'h1 && op <= 4'h4) lat += 1 + ew;
            if (op == 4'h2 || op == 4'h3) lat += 1;
            gen(instruction, fw, ew, rb(), rb());
            run_trace($sformatf("rand%0d_%h", n, instruction), lat);
        end

        // Reset while LDA waits in EXEC_MEM.
        instruction = 8'h1C;
        step(1'b1, 0, 0, 3'd0, S_MAR_PC, "mr_fa");
        step(1'b1, 0, 0, 3'd1, S_MEM_RD | S_LOAD_IR | S_PC_INC, "mr_fm");
        step(1'b0, 0, 0, 3'd2, S_MAR_IR, "mr_dec");
        step(1'b0, 0, 0, 3'd3, S_MEM_RD, "mr_exec");
        mem_ready = 1'b0;
        #2 reset_n = 1'b0;
        #1 chk("mr_in_reset", {t_state, obs}, 19'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        instruction = 8'h00;
        step(1'b1, 0, 0, 3'd0, S_MAR_PC, "mr_after_fa");
        step(1'b1, 0, 0, 3'd1, S_MEM_RD | S_LOAD_IR | S_PC_INC, "mr_after_fm");
        step(1'b1, 0, 0, 3'd2, 16'h0, "mr_after_dec");

        // HLT holds regardless of inputs; only reset leaves it.
        instruction = 8'hF0;
        step(1'b1, 0, 0, 3'd0, S_MAR_PC, "hlt_fa");
        step(1'b1, 0, 0, 3'd1, S_MEM_RD | S_LOAD_IR | S_PC_INC, "hlt_fm");
        step(1'b1, 0, 0, 3'd2, 16'h0, "hlt_dec");
        for (int n = 0; n < 22; n++)
            step(rb(), rb(), rb(), 3'd7, S_HALT, $sformatf("hlt_hold%0d", n));
        #1 reset_n = 1'b0;
        #1 chk("hlt_in_reset", {t_state, obs}, 19'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        instruction = 8'h53;
        gen(8'h53, 0, 0, 0, 0);
        run_trace("hlt_recover_ldi", 3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
